// File: rtl/proc_pkg.sv
// Shared opcode/state encodings and decode helpers for the 24-bit processor control path.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'h0,
      OP_MULTI = 4'h1,
      OP_DIV   = 4'h3,
      OP_ADD   = 4'h4,
      OP_LDR   = 4'h5,
      OP_STR   = 4'h6,
      OP_BCND  = 4'h8,
      OP_ADDI  = 4'hF
   } opcode_t;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_EXEC      = 4'd3,
      ST_MEM       = 4'd4,
      ST_DIV_WAIT  = 4'd5,
      ST_WB        = 4'd6,
      ST_HALT      = 4'd7,
      ST_STEP_WAIT = 4'd8
   } state_t;

   // Bit n set when opcode n takes its second operand from the immediate field.
   localparam logic [15:0] IMM_OPS = 16'h806A;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTI, OP_DIV, OP_ADD,
         OP_LDR, OP_STR, OP_BCND, OP_ADDI: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw push-button.
// pulse is registered: high for one cycle, three clocks after the button rises.
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);
   // sync[1:0] is the synchroniser, sync[2] the previous synchronised value.
   logic [2:0] sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= '0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[1:0], btn};
         pulse <= sync[1] & ~sync[2];
      end
   end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle sequencer: owns pc/ir and steps each instruction through FETCH..WB with registered strobes.
// Define SEQ_STEP_EN to park in STEP_WAIT after every instruction until a btn[1] edge.
module proc_sequencer
   import proc_pkg::*;
#(
   parameter logic [15:0] LAST_PC     = 16'hFFFF,
   parameter int          DIV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  btn,
   input  logic [23:0] inst,
   input  logic        br_taken,
   input  logic        div_done,
   output logic [15:0] pc,
   output logic [23:0] ir,
   output logic [3:0]  alu_op,
   output logic        imm_sel,
   output logic        div_start,
   output logic        rf_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic        data_en,
   output logic        busy,
   output logic        halted,
   output logic        fault
);
   localparam int DCW = $clog2(DIV_TIMEOUT + 1);

   state_t         state;
   state_t         state_nxt;
   logic [3:0]     op;
   logic [15:0]    pc_nxt;
   logic [DCW-1:0] div_cnt;
   logic           run_pulse;
   logic           complete;
   logic           fault_set;

   assign op      = ir[23:20];
   assign alu_op  = op;
   assign imm_sel = IMM_OPS[op];

   btn_edge_sync u_run_sync (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[0]),
      .pulse (run_pulse)
   );

`ifdef SEQ_STEP_EN
   logic step_pulse;
   logic unused_btn;

   btn_edge_sync u_step_sync (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[1]),
      .pulse (step_pulse)
   );
   assign unused_btn = ^btn[3:2];
`else
   logic unused_btn;
   assign unused_btn = ^btn[3:1];
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      complete  = 1'b0;
      fault_set = 1'b0;
      case (state)
         ST_IDLE:   if (run_pulse) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (!is_legal(op)) begin
               fault_set = 1'b1;
               state_nxt = ST_HALT;
            end else if (op == OP_DIV) begin
               state_nxt = ST_DIV_WAIT;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (op == OP_BCND)                     complete  = 1'b1;
            else if (op == OP_LDR || op == OP_STR) state_nxt = ST_MEM;
            else                                   state_nxt = ST_WB;
         end
         ST_MEM: begin
            if (op == OP_STR) complete  = 1'b1;
            else              state_nxt = ST_WB;
         end
         ST_DIV_WAIT: begin
            // A completion arriving on the final allowed cycle still wins over the timeout.
            if (div_done) begin
               state_nxt = ST_WB;
            end else if (div_cnt == DCW'(DIV_TIMEOUT - 1)) begin
               fault_set = 1'b1;
               state_nxt = ST_HALT;
            end
         end
         ST_WB:   complete  = 1'b1;
         ST_HALT: state_nxt = ST_HALT;
`ifdef SEQ_STEP_EN
         ST_STEP_WAIT: if (step_pulse) state_nxt = ST_FETCH;
`endif
         default: state_nxt = ST_HALT;
      endcase

      if (complete) begin
         if (pc == LAST_PC) begin
            state_nxt = ST_HALT;
         end else begin
            // Only BCND completes out of EXEC, so br_taken is never looked at elsewhere.
            pc_nxt = (op == OP_BCND && br_taken) ? {8'h00, ir[7:0]} : pc + 16'd1;
`ifdef SEQ_STEP_EN
            state_nxt = ST_STEP_WAIT;
`else
            state_nxt = ST_FETCH;
`endif
         end
      end
   end

   // Strobes are registered from the next state so each one lines up with the state it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         pc        <= '0;
         ir        <= '0;
         div_cnt   <= '0;
         fault     <= 1'b0;
         div_start <= 1'b0;
         rf_we     <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         data_en   <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         if (state == ST_FETCH) ir <= inst;
         div_cnt   <= (state == ST_DIV_WAIT) ? div_cnt + DCW'(1) : '0;
         fault     <= fault | fault_set;
         div_start <= (state == ST_DECODE) && (state_nxt == ST_DIV_WAIT);
         rf_we     <= (state_nxt == ST_WB);
         mem_re    <= (state_nxt == ST_MEM) && (op == OP_LDR);
         mem_we    <= (state_nxt == ST_MEM) && (op == OP_STR);
         data_en   <= (state_nxt == ST_MEM) && (op == OP_STR);
         busy      <= !(state_nxt inside {ST_IDLE, ST_HALT, ST_STEP_WAIT});
         halted    <= (state_nxt == ST_HALT);
      end
   end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: single-instruction table, hand-written corner sequences,
// and random programs compared cycle by cycle against an instruction-level model.
module tb_proc_sequencer;

   localparam logic [15:0] LAST = 16'h0002;
   localparam logic [23:0] ILL  = 24'h200000;
   localparam logic [23:0] ADDI = 24'hF66060;

   // Strobe groups {div_start, rf_we, mem_re, mem_we, data_en}.
   localparam logic [4:0] S_NONE = 5'b00000;
   localparam logic [4:0] S_DS   = 5'b10000;
   localparam logic [4:0] S_RF   = 5'b01000;
   localparam logic [4:0] S_RE   = 5'b00100;
   localparam logic [4:0] S_WR   = 5'b00011;

   logic        clk, rst;
   logic [3:0]  btn;
   logic [23:0] inst;
   logic        br_taken, div_done;
   logic [15:0] pc;
   logic [23:0] ir;
   logic [3:0]  alu_op;
   logic        imm_sel, div_start, rf_we, mem_re, mem_we, data_en, busy, halted, fault;

   logic [23:0] imem [0:255];
   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        br;
      logic        dd;
      logic [52:0] exp;
   } cyc_t;
   cyc_t trace[$];

   typedef struct {
      logic [23:0] inst;
      logic        br;
      int          lat;
      int          cyc;
      logic [19:0] cnt;   // nibbles: rf_we, mem_re, mem_we, data_en, div_start
      logic [15:0] pc;
      logic        flt;
      logic        imm;
   } row_t;
   row_t rows[$];

   assign inst = imem[pc[7:0]];

   proc_sequencer #(.LAST_PC(LAST), .DIV_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .btn(btn), .inst(inst), .br_taken(br_taken), .div_done(div_done),
      .pc(pc), .ir(ir), .alu_op(alu_op), .imm_sel(imm_sel), .div_start(div_start),
      .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we), .data_en(data_en),
      .busy(busy), .halted(halted), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic op_legal(input logic [3:0] o);
      return o inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'hF};
   endfunction

   function automatic logic imm_of(input logic [3:0] o);
      return o inside {4'h1, 4'h3, 4'hF, 4'h5, 4'h6};
   endfunction

   function automatic logic [52:0] outs();
      return {pc, ir, alu_op, imm_sel, div_start, rf_we, mem_re, mem_we, data_en, busy, halted, fault};
   endfunction

   function automatic logic [52:0] ev(input logic [15:0] p, input logic [23:0] r,
                                      input logic [4:0] st, input logic [2:0] sys);
      return {p, r, r[23:20], imm_of(r[23:20]), st, sys};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic rdd();
      return ($urandom_range(0, 3) == 0);
   endfunction

   task automatic add(input logic b, input logic d, input logic [52:0] e);
      cyc_t c;
      c.br  = b;
      c.dd  = d;
      c.exp = e;
      trace.push_back(c);
   endtask

   // Expands the program in imem into the expected per-cycle outputs, one instruction at a time,
   // from the per-opcode cycle recipes; inputs outside their sampling windows are random noise.
   task automatic build_trace(input int max_instr);
      logic [15:0] mpc = 16'h0000;
      logic [15:0] nxt;
      logic [23:0] mir = 24'h0;
      logic [23:0] cur;
      logic [3:0]  o;
      logic        mflt = 1'b0;
      logic        stop = 1'b0;
      logic        done_i, tk;
      int          lat;
      trace.delete();
      for (int n = 0; n < max_instr && !stop; n++) begin
         cur    = imem[mpc[7:0]];
         o      = cur[23:20];
         nxt    = mpc + 16'd1;
         done_i = 1'b0;
         add(rb(), rdd(), ev(mpc, mir, S_NONE, 3'b100));
         mir = cur;
         add(rb(), rdd(), ev(mpc, mir, S_NONE, 3'b100));
         if (!op_legal(o)) begin
            mflt = 1'b1;
            stop = 1'b1;
         end else if (o == 4'h3) begin
            lat = $urandom_range(0, 70);
            for (int k = 1; k <= 64 && k <= lat + 1; k++)
               add(rb(), (k == lat + 1), ev(mpc, mir, (k == 1) ? S_DS : S_NONE, 3'b100));
            if (lat + 1 <= 64) begin
               add(rb(), rdd(), ev(mpc, mir, S_RF, 3'b100));
               done_i = 1'b1;
            end else begin
               mflt = 1'b1;
               stop = 1'b1;
            end
         end else if (o == 4'h8) begin
            tk = rb();
            add(tk, rdd(), ev(mpc, mir, S_NONE, 3'b100));
            if (tk) nxt = {8'h00, mir[7:0]};
            done_i = 1'b1;
         end else begin
            add(rb(), rdd(), ev(mpc, mir, S_NONE, 3'b100));
            if (o == 4'h5) add(rb(), rdd(), ev(mpc, mir, S_RE, 3'b100));
            if (o == 4'h6) add(rb(), rdd(), ev(mpc, mir, S_WR, 3'b100));
            else           add(rb(), rdd(), ev(mpc, mir, S_RF, 3'b100));
            done_i = 1'b1;
         end
         if (done_i) begin
            if (mpc == LAST) stop = 1'b1;
            else             mpc  = nxt;
         end
      end
      if (stop)
         for (int h = 0; h < 4; h++) add(rb(), rdd(), ev(mpc, mir, S_NONE, {2'b01, mflt}));
   endtask

   task automatic run_trace(input string name);
      int bad0 = n_bad;
      for (int i = 0; i < trace.size() && n_bad == bad0; i++) begin
         check(name, 64'(outs()), 64'(trace[i].exp));
         br_taken = trace[i].br;
         div_done = trace[i].dd;
         @(negedge clk);
      end
      br_taken = 1'b0;
      div_done = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      btn      = 4'h0;
      br_taken = 1'b0;
      div_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Leaves the bench on the falling edge inside the first FETCH cycle.
   task automatic start_run();
      int k = 0;
      do_reset();
      btn[0] = 1'b1;
      do begin
         @(negedge clk);
         k++;
      end while (!busy && k < 10);
      btn[0] = 1'b0;
      check("start_busy", 64'(busy), 64'd1);
   endtask

   function automatic logic [23:0] rand_inst();
      logic [3:0] o;
      logic       want_ill = ($urandom_range(0, 29) == 0);
      do o = 4'($urandom_range(0, 15)); while (op_legal(o) == want_ill);
      return {o, 20'($urandom)};
   endfunction

   task automatic add_row(input logic [23:0] i, input logic b, input int l, input int c,
                          input logic [19:0] n, input logic [15:0] p, input logic f, input logic m);
      row_t r;
      r.inst = i; r.br = b; r.lat = l; r.cyc = c; r.cnt = n; r.pc = p; r.flt = f; r.imm = m;
      rows.push_back(r);
   endtask

   initial begin
      int          cyc, ds_at;
      logic [3:0]  c_rf, c_re, c_we, c_den, c_ds;
      logic        imm_seen;

      add_row(ADDI,      1'b0,  0,  4, 20'h10000, 16'h0001, 1'b0, 1'b1);
      add_row(24'h806511, 1'b1,  0,  3, 20'h00000, 16'h0011, 1'b0, 1'b0);
      add_row(24'h806511, 1'b0,  0,  3, 20'h00000, 16'h0001, 1'b0, 1'b0);
      add_row(24'h8000FF, 1'b1,  0,  3, 20'h00000, 16'h00FF, 1'b0, 1'b0);
      add_row(24'h311003, 1'b0, 10, 14, 20'h10001, 16'h0001, 1'b0, 1'b1);
      add_row(24'h311003, 1'b0,  0,  4, 20'h10001, 16'h0001, 1'b0, 1'b1);
      add_row(24'h311003, 1'b0, 63, 67, 20'h10001, 16'h0001, 1'b0, 1'b1);
      add_row(24'h311003, 1'b0, -1, 66, 20'h00001, 16'h0000, 1'b1, 1'b1);
      add_row(24'h670001, 1'b0,  0,  4, 20'h00110, 16'h0001, 1'b0, 1'b1);
      add_row(24'h570001, 1'b0,  0,  5, 20'h11000, 16'h0001, 1'b0, 1'b1);
      add_row(ILL,        1'b0,  0,  2, 20'h00000, 16'h0000, 1'b1, 1'b0);
      add_row(24'h7ABCDE, 1'b0,  0,  2, 20'h00000, 16'h0000, 1'b1, 1'b0);
      add_row(24'h000123, 1'b0,  0,  4, 20'h10000, 16'h0001, 1'b0, 1'b0);
      add_row(24'h4ABCDE, 1'b0,  0,  4, 20'h10000, 16'h0001, 1'b0, 1'b0);
      add_row(24'h1FFFFF, 1'b0,  0,  4, 20'h10000, 16'h0001, 1'b0, 1'b1);

      rst = 1'b1; btn = 4'h0; br_taken = 1'b0; div_done = 1'b0;
      for (int a = 0; a < 256; a++) imem[a] = ILL;
      #2 rst = 1'b0;
      #1 check("reset_state", 64'(outs()), 64'd0);
      do_reset();

      // Single-instruction table: count cycles and strobes while pc still reads 0.
      for (int r = 0; r < rows.size(); r++) begin
         for (int a = 0; a < 256; a++) imem[a] = ILL;
         imem[0] = rows[r].inst;
         start_run();
         br_taken = rows[r].br;
         cyc = 0; ds_at = -1; imm_seen = 1'b0;
         c_rf = 0; c_re = 0; c_we = 0; c_den = 0; c_ds = 0;
         while (pc == 16'h0000 && !halted && cyc < 200) begin
            cyc++;
            if (cyc == 2) imm_seen = imm_sel;
            c_rf  += 4'(rf_we);
            c_re  += 4'(mem_re);
            c_we  += 4'(mem_we);
            c_den += 4'(data_en);
            c_ds  += 4'(div_start);
            if (div_start) ds_at = cyc;
            div_done = (ds_at > 0 && rows[r].lat >= 0 && cyc == ds_at + rows[r].lat);
            @(negedge clk);
         end
         div_done = 1'b0;
         check("tbl_cycles",  64'(cyc), 64'(rows[r].cyc));
         check("tbl_strobes", 64'({c_rf, c_re, c_we, c_den, c_ds}), 64'(rows[r].cnt));
         check("tbl_pc",      64'(pc), 64'(rows[r].pc));
         check("tbl_fault",   64'(fault), 64'(rows[r].flt));
         check("tbl_imm_alu", 64'({imm_seen, alu_op}), 64'({rows[r].imm, rows[r].inst[23:20]}));
      end

      // Run-button latency, then three ADDIs halting at LAST_PC.
      for (int a = 0; a < 256; a++) imem[a] = ILL;
      for (int a = 0; a < 3; a++) imem[a] = ADDI;
      do_reset();
      btn[0] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("run_latency", 64'(busy), 64'(k == 4));
      end
      btn[0] = 1'b0;
      build_trace(10);
      run_trace("last_pc_trace");
      check("last_pc_halt", 64'({halted, fault, pc}), 64'({1'b1, 1'b0, LAST}));

      // STR then LDR back to back.
      imem[0] = 24'h670001;
      imem[1] = 24'h570001;
      imem[2] = ILL;
      start_run();
      build_trace(10);
      run_trace("str_ldr_trace");

      // Asynchronous reset in the EXEC cycle of the second instruction.
      imem[0] = ADDI;
      imem[1] = ADDI;
      start_run();
      repeat (6) @(negedge clk);
      check("pre_reset_pc", 64'(pc), 64'h1);
      rst = 1'b0;
      #1 check("reset_mid_exec", 64'(outs()), 64'd0);
      @(negedge clk);
      check("reset_held", 64'(outs()), 64'd0);
      rst = 1'b1;

      for (int p = 0; p < 20; p++) begin
         for (int a = 0; a < 256; a++) imem[a] = rand_inst();
         start_run();
         build_trace(30);
         run_trace("random_trace");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Multi-cycle control unit for the 24-bit-instruction processor core. It owns the program counter, latches instructions from instruction memory, and steps each instruction through fetch/decode/execute/memory/write-back, issuing one-hot control strobes to the ALU, divider, register file and data memory. It also generates the `data_en` strobe that marks a valid 40-bit output word on the processor's `data` bus.

## Interface
- `LAST_PC`, 16'hFFFF: the sequencer halts after completing the instruction at this address.
- `DIV_TIMEOUT`, 64: maximum cycles spent in DIV_WAIT before a fault halt.
- `clk  in  1`: core clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `btn  in  4`: raw push-buttons.
  - `[0]` run.
  - `[1]` step; used only with `SEQ_STEP_EN`.
  - `[3:2]` unused.
- `inst  in  24`: instruction-memory read data for address `pc`, valid in the same cycle (combinational ROM).
- `br_taken  in  1`: datapath compare result for BCND; 1 means take the branch.
- `div_done  in  1`: divider completion, a single-cycle pulse.
- `pc  out  16`: program counter.
- `ir  out  24`: latched instruction.
- `alu_op  out  4`: `ir[23:20]`.
- `imm_sel  out  1`: 1 for MULTI, DIV, ADDI and LDR/STR addressing.
- `div_start  out  1`: one-cycle pulse.
- `rf_we  out  1`: register-file write enable.
- `mem_re  out  1`: data-memory read enable.
- `mem_we  out  1`: data-memory write enable.
- `data_en  out  1`: output-word strobe.
- `busy  out  1`: high in every state except IDLE and HALT.
- `halted  out  1`: high in HALT.
- `fault  out  1`: sticky; set by an illegal opcode or a divide timeout.

## Operation
- Opcodes, taken from `ir[23:20]`:
  - MULT 0000, MULTI 0001, DIV 0011, ADD 0100, LDR 0101, STR 0110, BCND 1000, ADDI 1111.
  - Any other value is illegal.
- `btn[0]` is synchronised with two flops, then rising-edge detected to produce `run_pulse`.
- States:
  - IDLE: waits for `run_pulse`, then goes to FETCH.
  - FETCH: `ir <= inst`, then DECODE.
  - DECODE:
    - illegal opcode: set `fault`, go to HALT;
    - DIV: go to DIV_WAIT and pulse `div_start` on this transition;
    - all other legal opcodes: go to EXEC.
  - EXEC:
    - ALU ops: go to WB.
    - LDR, STR: go to MEM.
    - BCND: completes the instruction; no register write.
  - MEM:
    - LDR: `mem_re` = 1, then WB.
    - STR: `mem_we` = 1 and `data_en` = 1, then the instruction completes.
  - DIV_WAIT: stays until `div_done`, then WB. After `DIV_TIMEOUT` cycles without `div_done`: set `fault`, go to HALT.
  - WB: `rf_we` = 1; the instruction completes.
  - HALT: absorbing; left only by reset.
- Instruction completion (the last cycle of each instruction) updates the PC:
  - BCND with `br_taken` = 1: `pc <= {8'h00, ir[7:0]}`.
  - Otherwise: `pc <= pc + 1`, wrapping from 16'hFFFF to 0.
  - If the completing `pc == LAST_PC`: go to HALT with `pc` unchanged. Otherwise go to FETCH.
- All strobes are registered Moore outputs of the current state. `div_start` is a registered one-cycle pulse.
- `br_taken` is sampled only in EXEC of BCND. `div_done` is sampled only in DIV_WAIT; a pulse arriving in any other state is ignored.

## Timing
- Reset values: `pc` = 0, `ir` = 0, all strobes 0, `busy` = 0, `halted` = 0, `fault` = 0, state IDLE, synchroniser flops 0.
- Reset is asynchronous at any point, including mid-instruction; no strobe may remain high afterwards.
- `run_pulse` is seen 3 cycles after the button's rising edge.
- Per-instruction cycle counts, FETCH to the next FETCH:
  - ALU ops (MULT, MULTI, ADD, ADDI): 4.
  - LDR: 5.
  - STR: 4.
  - BCND: 3.
  - DIV: 4 + divider latency.
- `rf_we`, `mem_we`, `mem_re` and `data_en` are each high for exactly one cycle per instruction.

## Configuration
- `SEQ_STEP_EN` defined:
  - `btn[1]` gets its own synchroniser and edge detector.
  - After each instruction completes, the FSM parks in STEP_WAIT (`busy` = 0) until a `btn[1]` edge, then goes to FETCH.
  - `btn[0]` still starts the sequencer from IDLE.
- `SEQ_STEP_EN` undefined: STEP_WAIT and its logic are absent; instructions run back-to-back.

## Structure
- Package `proc_pkg` holds:
  - the opcode enum (4 bits);
  - the state enum;
  - the `IMM_OPS` decode constant.
- One sub-module, `btn_edge_sync`: two-flop synchroniser plus rising-edge detector. It is instantiated once for `btn[0]`, and a second time for `btn[1]` when `SEQ_STEP_EN` is defined.

## Test plan
- Reset, then pulse `btn[0]`, with imem[0] = 24'hF66060 (ADDI): expect `rf_we` high exactly once, 4 cycles after FETCH, and `pc` = 1.
- BCND 24'h806511 with `br_taken` = 1: expect `pc` = 17 (0x11) after 3 cycles. Repeat with `br_taken` = 0: expect `pc` + 1.
- DIV 24'h311003 with `div_done` pulsed 10 cycles after `div_start`: expect one `rf_we` and 14 cycles total. With no `div_done`: expect `fault` = 1 and `halted` = 1 after 64 cycles in DIV_WAIT.
- STR 24'h670001 then LDR 24'h570001: expect `data_en` and `mem_we` together for one cycle, then `mem_re` for one cycle, then `rf_we` for one cycle.
- Illegal opcode 24'h200000: expect HALT straight from DECODE with `fault` = 1 and no strobes asserted.
- `LAST_PC` = 2 with three ADDIs in imem: expect HALT after the third ADDI with `pc` = 2. Asserting `rst` low mid-EXEC: expect `pc` = 0 and IDLE immediately.
